// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the multiply/divide sequencer
package muldiv_pkg;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  typedef enum logic {M_MUL, M_DIV} mode_t;
  localparam logic [2:0] MD_NOP   = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;
  localparam logic [1:0] RD_NONE  = 2'b00;
  localparam logic [1:0] RD_HI    = 2'b01;
  localparam logic [1:0] RD_LO    = 2'b10;
  function automatic logic md_active(input logic [2:0] op);
    return op != MD_NOP && op != 3'b111;
  endfunction
  function automatic logic rd_active(input logic [1:0] rd);
    return rd == RD_HI || rd == RD_LO;
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring shift-subtract divide iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  // mul: acc={hi,multiplier}, add on lsb then shift right; div: acc={rem,quotient}, shift left and trial-subtract
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    sh       = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge       = sh >= {1'b0, opnd};
    diff     = sh[WIDTH-1:0] - opnd;
    acc_next = (mode == M_DIV) ? {ge ? diff : sh[WIDTH-1:0], acc[WIDTH-2:0], ge}
                               : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/DIV sequencer owning HI/LO with core stall generation
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       md_op,
  input  logic [1:0]       rd_hilo_c,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             stall,
  output logic             busy,
  output logic             div0
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t             state, state_n;
  mode_t              mode;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod;
  logic [WIDTH-1:0]   hi, lo, opnd, mag_a, mag_b;
  logic               neg, rneg, idle, sgn, go_mul, is_dop, go_div, div_zero;
  assign idle       = state == S_IDLE;
  assign busy       = ~idle;
  assign sgn        = md_op == MD_MULT || md_op == MD_DIV;
  assign go_mul     = idle && (md_op == MD_MULT || md_op == MD_MULTU);
  assign is_dop     = idle && (md_op == MD_DIV || md_op == MD_DIVU);
  assign go_div     = is_dop && |op_b;
  assign div_zero   = is_dop && ~|op_b;
  assign mag_a      = (sgn && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b      = (sgn && op_b[WIDTH-1]) ? -op_b : op_b;
  assign prod       = neg ? -acc : acc;
  assign stall      = busy && (md_active(md_op) || rd_active(rd_hilo_c));
  assign hilo_rdata = rd_hilo_c == RD_HI ? hi : rd_hilo_c == RD_LO ? lo : '0;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode    (mode),
    .acc     (acc),
    .opnd    (opnd),
    .acc_next(acc_step)
  );
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end
  // next state: iterate WIDTH steps, then one FIX cycle back to IDLE
  always_comb begin
    state_n = state == S_FIX ? S_IDLE :
              (state != S_IDLE && cnt == LAST) ? S_FIX :
              go_mul ? S_MUL : go_div ? S_DIV : state;
  end
  // operand latch, iteration, sign fix-up and HI/LO writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      acc  <= '0;
      opnd <= '0;
      mode <= M_MUL;
      neg  <= 1'b0;
      rneg <= 1'b0;
      div0 <= 1'b0;
    end else begin
      div0 <= div_zero;
      if (go_mul || go_div) begin
        opnd <= go_mul ? mag_a : mag_b;
        acc  <= {{WIDTH{1'b0}}, go_mul ? mag_b : mag_a};
        mode <= go_div ? M_DIV : M_MUL;
        neg  <= sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        rneg <= sgn && op_a[WIDTH-1];
        cnt  <= '0;
      end else if (state == S_MUL || state == S_DIV) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end else if (state == S_FIX) begin
        if (mode == M_DIV) begin
          lo <= neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          hi <= rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end else begin
          {hi, lo} <= prod;
        end
      end
      if (div_zero) begin
        hi <= op_a;
        lo <= '1;
      end
      if (idle && md_op == MD_MTHI) hi <= op_a;
      if (idle && md_op == MD_MTLO) lo <= op_a;
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors with a read scoreboard for muldiv_seq
module tb_muldiv_seq;
  import muldiv_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  md_op = MD_NOP;
  logic [1:0]  rd_hilo_c = RD_NONE;
  logic [31:0] op_a = '0, op_b = '0;
  logic [31:0] hilo_rdata;
  logic        stall, busy, div0;
  int          errors = 0, checks = 0;
  typedef struct {
    string       name;
    logic [31:0] v;
  } exp_t;
  exp_t exp_q[$];

  muldiv_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_op     (md_op),
    .rd_hilo_c (rd_hilo_c),
    .op_a      (op_a),
    .op_b      (op_b),
    .hilo_rdata(hilo_rdata),
    .stall     (stall),
    .busy      (busy),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: an unstalled MFHI/MFLO presents data; compare against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rd_hilo_c != RD_NONE && !stall) begin
      if (exp_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, hilo_rdata, e.v);
      end
    end
  end

  // all tasks start and end just after a rising edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op;
    op_a  = a;
    op_b  = b;
    @(posedge clk); #1;
    md_op = MD_NOP;
  endtask

  task automatic read(input string name, input logic [1:0] sel, input logic [31:0] v, output int n);
    exp_t e;
    e.name = name;
    e.v    = v;
    exp_q.push_back(e);
    rd_hilo_c = sel;
    n = 0;
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (stall) begin
      check({name, "_timeout"}, 32'd1, 32'd0);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    rd_hilo_c = RD_NONE;
    md_op = MD_NOP;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_div0", div0, 0);
    check("rst_stall", stall, 0);
    @(posedge clk); #1;
    read("rst_hi", RD_HI, 32'h0, n);
    read("rst_lo", RD_LO, 32'h0, n);
    // signed multiply with an immediately following MFLO
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    read("t1_lo", RD_LO, 32'hFFFF_FFEB, n);
    check("t1_stall_cycles", n, 33);
    read("t1_hi", RD_HI, 32'hFFFF_FFFF, n);
    check("t1_hi_nostall", n, 0);
    // unsigned extreme product and exact busy length
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    check("t2_busy_cycles", n, 33);
    read("t2_hi", RD_HI, 32'hFFFF_FFFE, n);
    read("t2_lo", RD_LO, 32'h0000_0001, n);
    // signed and unsigned division
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    read("t3_div_lo", RD_LO, 32'hFFFF_FFFD, n);
    read("t3_div_hi", RD_HI, 32'hFFFF_FFFF, n);
    issue(MD_DIVU, 32'd100, 32'd7);
    read("t3_divu_lo", RD_LO, 32'd14, n);
    read("t3_divu_hi", RD_HI, 32'd2, n);
    // divide by zero
    issue(MD_DIV, 32'h0000_1234, 32'd0);
    @(negedge clk);
    check("t4_busy", busy, 0);
    check("t4_div0_pulse", div0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_div0_drop", div0, 0);
    @(posedge clk); #1;
    read("t4_hi", RD_HI, 32'h0000_1234, n);
    read("t4_lo", RD_LO, 32'hFFFF_FFFF, n);
    // unrelated instructions never stall while busy
    issue(MD_MULT, 32'd5, 32'hFFFF_FFFD);
    for (int i = 0; i < 5; i++) begin
      op_a = 32'(i * 3 + 1);
      @(negedge clk);
      check("t5_nop_stall", stall, 0);
      check("t5_busy", busy, 1);
      @(posedge clk); #1;
    end
    read("t5_hi", RD_HI, 32'hFFFF_FFFF, n);
    check("t5_stall_cycles", n, 28);
    read("t5_lo", RD_LO, 32'hFFFF_FFF1, n);
    // move-to followed by read, and same-cycle write+read returns the old value
    issue(MD_MTHI, 32'hA5A5_A5A5, 32'd0);
    read("t6_mthi", RD_HI, 32'hA5A5_A5A5, n);
    check("t6_mthi_nostall", n, 0);
    md_op = MD_MTLO;
    op_a  = 32'h1111_1111;
    read("t6_rw_old", RD_LO, 32'hFFFF_FFF1, n);
    read("t6_rw_new", RD_LO, 32'h1111_1111, n);
    // signed overflow division wraps without trapping
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    read("ovf_lo", RD_LO, 32'h8000_0000, n);
    read("ovf_hi", RD_HI, 32'h0, n);
    // reset in the middle of a divide drops it
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_busy_after_rst", busy, 0);
    @(posedge clk); #1;
    read("t7_hi", RD_HI, 32'h0, n);
    read("t7_lo", RD_LO, 32'h0, n);
    repeat (40) @(posedge clk);
    #1;
    read("t7_hi_late", RD_HI, 32'h0, n);
    read("t7_lo_late", RD_LO, 32'h0, n);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
